cond_exec_unit: RTL and testbench

//  Consumer end of the ALU flag interface: holds the architectural NZCV register, evaluates the
//  4-bit ARM condition field against it and gates PCS/RegW/MemW for the execute stage.

---
 rtl/cond_pkg.sv | 30 +++
 rtl/cond_check.sv | 41 ++++
 rtl/cond_exec_unit.sv | 91 +++++++++
 tb/tb_cond_exec_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execute slice: ARM condition codes,
// NZCV bit positions and FlagW field positions.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational evaluation of a 4-bit ARM condition field against NZCV.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n_s, z_s, c_s, v_s;

  assign n_s = flags[FLAG_N];
  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign v_s = flags[FLAG_V];

  // Condition decode; NV never passes
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z_s;
      COND_NE: cond_ex = ~z_s;
      COND_CS: cond_ex = c_s;
      COND_CC: cond_ex = ~c_s;
      COND_MI: cond_ex = n_s;
      COND_PL: cond_ex = ~n_s;
      COND_VS: cond_ex = v_s;
      COND_VC: cond_ex = ~v_s;
      COND_HI: cond_ex = c_s & ~z_s;
      COND_LS: cond_ex = ~c_s | z_s;
      COND_GE: cond_ex = (n_s == v_s);
      COND_LT: cond_ex = (n_s != v_s);
      COND_GT: cond_ex = ~z_s & (n_s == v_s);
      COND_LE: cond_ex = z_s | (n_s != v_s);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Execute-stage condition unit: architectural NZCV register, write gating and an
// optional saturating skipped-instruction counter (enabled by COND_SKIP_CNT_EN).
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Valid,
  input  logic             Stall,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic             CondEx,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SkipCount
);

  logic [3:0] flags_r;
  logic       cond_ex_s;
  logic       issue_s;
  logic       pass_s;

  cond_check u_cond_check (
    .cond    (Cond),
    .flags   (flags_r),
    .cond_ex (cond_ex_s)
  );

  // An instruction only takes effect when present and not held
  assign issue_s  = Valid & ~Stall;
  assign pass_s   = issue_s & cond_ex_s;

  assign CondEx   = cond_ex_s;
  assign PCSrc    = PCS & pass_s;
  assign RegWrite = RegW & ~NoWrite & pass_s;
  assign MemWrite = MemW & pass_s;
  assign Flags    = flags_r;

  // NZCV register: N/Z and C/V pairs are written independently
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      flags_r <= 4'b0000;
    end else if (pass_s) begin
      if (FlagW[FW_NZ]) begin
        flags_r[FLAG_N] <= ALUFlags[FLAG_N];
        flags_r[FLAG_Z] <= ALUFlags[FLAG_Z];
      end else begin
        flags_r[FLAG_N] <= flags_r[FLAG_N];
        flags_r[FLAG_Z] <= flags_r[FLAG_Z];
      end
      if (FlagW[FW_CV]) begin
        flags_r[FLAG_C] <= ALUFlags[FLAG_C];
        flags_r[FLAG_V] <= ALUFlags[FLAG_V];
      end else begin
        flags_r[FLAG_C] <= flags_r[FLAG_C];
        flags_r[FLAG_V] <= flags_r[FLAG_V];
      end
    end else begin
      flags_r <= flags_r;
    end
  end

`ifdef COND_SKIP_CNT_EN
  logic [CNT_W-1:0] skip_cnt_r;

  // Skip counter sticks at all-ones rather than wrapping
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      skip_cnt_r <= {CNT_W{1'b0}};
    end else if (issue_s && !cond_ex_s && (skip_cnt_r != {CNT_W{1'b1}})) begin
      skip_cnt_r <= skip_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      skip_cnt_r <= skip_cnt_r;
    end
  end

  assign SkipCount = skip_cnt_r;
`else
  assign SkipCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: a driver pushes expected outputs from a
// behavioural NZCV model, a negedge monitor pops and compares.
module tb_cond_exec_unit;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             Reset_n;
  logic             Valid, Stall, PCS, RegW, MemW, NoWrite;
  logic [3:0]       Cond, ALUFlags;
  logic [1:0]       FlagW;
  logic             CondEx, PCSrc, RegWrite, MemWrite;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] SkipCount;

  typedef struct {
    int         id;
    logic       cond_ex;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic [3:0] flags;
    int         skip;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   step_id = 0;

  // Model state
  bit   m_n, m_z, m_c, m_v;
  int   m_skip;

  always #5 CLK = ~CLK;

  cond_exec_unit #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Valid(Valid), .Stall(Stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .CondEx(CondEx), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .Flags(Flags), .SkipCount(SkipCount)
  );

  function automatic bit passes(input logic [3:0] c);
    case (c)
      4'd0:  return m_z;
      4'd1:  return !m_z;
      4'd2:  return m_c;
      4'd3:  return !m_c;
      4'd4:  return m_n;
      4'd5:  return !m_n;
      4'd6:  return m_v;
      4'd7:  return !m_v;
      4'd8:  return m_c && !m_z;
      4'd9:  return !m_c || m_z;
      4'd10: return m_n == m_v;
      4'd11: return m_n != m_v;
      4'd12: return !m_z && (m_n == m_v);
      4'd13: return m_z || (m_n != m_v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit rst_n, input bit vld, input bit stl, input logic [3:0] c,
                      input logic [1:0] fw, input logic [3:0] alu, input bit pcs,
                      input bit regw, input bit memw, input bit nowr);
    exp_t e;
    bit   ok, go;
    @(posedge CLK);
    #1;
    Reset_n = rst_n; Valid = vld; Stall = stl; Cond = c; FlagW = fw; ALUFlags = alu;
    PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr;
    ok = passes(c);
    go = vld && !stl;
    e.id        = step_id;
    e.cond_ex   = ok;
    e.pc_src    = go && ok && pcs;
    e.reg_write = go && ok && regw && !nowr;
    e.mem_write = go && ok && memw;
    e.flags     = {m_n, m_z, m_c, m_v};
`ifdef COND_SKIP_CNT_EN
    e.skip      = m_skip;
`else
    e.skip      = 0;
`endif
    q.push_back(e);
    step_id++;
    // Model update taken at the next rising edge
    if (!rst_n) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_skip = 0;
    end else if (go) begin
      if (ok) begin
        if (fw[1]) begin m_n = alu[3]; m_z = alu[2]; end
        if (fw[0]) begin m_c = alu[1]; m_v = alu[0]; end
      end else if (m_skip < SAT) begin
        m_skip++;
      end
    end
  endtask

  task automatic idle_rst();
    step(1'b0, 1'b0, 1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle, compare mid-cycle
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (CondEx === e.cond_ex && PCSrc === e.pc_src && RegWrite === e.reg_write &&
          MemWrite === e.mem_write && Flags === e.flags && int'(SkipCount) == e.skip &&
          !$isunknown(SkipCount)) begin
        passed++;
      end else begin
        $display("FAIL step%0d: got CondEx=%b PCSrc=%b RegWrite=%b MemWrite=%b Flags=%b SkipCount=%0d, expected %b %b %b %b %b %0d",
                 e.id, CondEx, PCSrc, RegWrite, MemWrite, Flags, SkipCount,
                 e.cond_ex, e.pc_src, e.reg_write, e.mem_write, e.flags, e.skip);
      end
    end
  end

  initial begin
    Reset_n = 1'b0; Valid = 1'b0; Stall = 1'b0; Cond = 4'b1110; FlagW = 2'b00;
    ALUFlags = 4'b0000; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    {m_n, m_z, m_c, m_v} = 4'b0000;
    m_skip = 0;
    @(posedge CLK);

    // 1: reset state against EQ/NE/AL/NV
    step(1'b1, 1'b1, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0001, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b1111, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);

    // 2: CMP equal, then EQ passes and NE skips
    step(1'b1, 1'b1, 1'b0, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0001, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

    // 3: partial flag writes
    idle_rst();
    step(1'b1, 1'b1, 1'b0, 4'b1110, 2'b10, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b1110, 2'b01, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: failed condition leaves flags alone
    idle_rst();
    step(1'b1, 1'b1, 1'b0, 4'b0000, 2'b11, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: stall holds everything and gates writes
    step(1'b1, 1'b1, 1'b1, 4'b1110, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'b1111, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b1110, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: saturation, then reset mid-stream
    idle_rst();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, 1'b0, 4'b1111, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_rst();
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(posedge CLK);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
